// File: rtl/iwriteback.sv
// iwriteback: M/W pipeline register, load-data alignment, register-file write
// port sequencing (including a second beat for base writeback) and a
// retired-instruction counter.
module iwriteback #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             CondExM,
    input  logic             RegWriteM,
    input  logic             MemtoRegM,
    input  logic             PCSrcM,
    input  logic             BaseWriteM,
    input  logic [3:0]       RdM,
    input  logic [3:0]       RnM,
    input  logic [31:0]      ALUResultM,
    input  logic [31:0]      BaseResultM,
    input  logic [31:0]      ReadDataM,
    input  logic [3:0]       byteEnableM,
    output logic             RegWriteW,
    output logic [3:0]       RdW,
    output logic [31:0]      ResultW,
    output logic             PCSrcW,
    output logic             WbBusyW,
    output logic [CNT_W-1:0] RetiredW
);

    typedef enum logic {S_IDLE, S_BASE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_valid;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic              r_pcsrc;
    logic              r_basewrite;
    logic [3:0]        r_rd;
    logic [3:0]        r_rn;
    logic [31:0]       r_alu;
    logic [31:0]       r_base;
    logic [31:0]       r_rdata;
    logic [3:0]        r_be;
    logic [CNT_W-1:0]  r_retired;

    logic [31:0]       w_load;
    logic              w_base_pending;
    logic              w_retire;

    // A base write to the same register as the load is dropped: the load wins.
    assign w_base_pending = r_valid & r_basewrite & (r_rd != r_rn);

    // M/W register: held while stalled or while the base beat is pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_regwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_pcsrc     <= 1'b0;
            r_basewrite <= 1'b0;
            r_rd        <= '0;
            r_rn        <= '0;
            r_alu       <= '0;
            r_base      <= '0;
            r_rdata     <= '0;
            r_be        <= '0;
        end else if (!stall && !WbBusyW) begin
            r_valid     <= CondExM;
            r_regwrite  <= RegWriteM;
            r_memtoreg  <= MemtoRegM;
            r_pcsrc     <= PCSrcM;
            r_basewrite <= BaseWriteM;
            r_rd        <= RdM;
            r_rn        <= RnM;
            r_alu       <= ALUResultM;
            r_base      <= BaseResultM;
            r_rdata     <= ReadDataM;
            r_be        <= byteEnableM;
        end
    end

    // Load alignment: single lane -> byte, paired lanes -> halfword, else word.
    always_comb begin
        w_load = r_rdata;
        case (r_be)
            4'b0001: w_load = {24'h0, r_rdata[7:0]};
            4'b0010: w_load = {24'h0, r_rdata[15:8]};
            4'b0100: w_load = {24'h0, r_rdata[23:16]};
            4'b1000: w_load = {24'h0, r_rdata[31:24]};
            4'b0011: w_load = {16'h0, r_rdata[15:0]};
            4'b1100: w_load = {16'h0, r_rdata[31:16]};
            default: w_load = r_rdata;
        endcase
    end

    // Write-port outputs and next state.
    always_comb begin
        w_state_nxt = r_state;
        RdW         = r_rd;
        ResultW     = r_memtoreg ? w_load : r_alu;
        RegWriteW   = r_valid & r_regwrite;
        PCSrcW      = r_valid & r_pcsrc;
        WbBusyW     = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                WbBusyW  = w_base_pending;
                w_retire = r_valid & ~w_base_pending & ~stall;
                if (w_base_pending && !stall)
                    w_state_nxt = S_BASE;
            end
            S_BASE: begin
                RdW       = r_rn;
                ResultW   = r_base;
                RegWriteW = 1'b1;
                PCSrcW    = (r_rn == 4'd15);
                w_retire  = ~stall;
                if (!stall)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset abandons any pending base write.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Retired-instruction counter, bumped on the final beat of each instruction.
    always_ff @(posedge clk) begin
        if (reset)
            r_retired <= '0;
        else if (w_retire)
            r_retired <= r_retired + 1'b1;
    end

    assign RetiredW = r_retired;

endmodule

// File: tb/tb_iwriteback.sv
// Testbench for iwriteback: directed steps followed by random traffic, all
// checked against a beat-queue model of the write port.
module tb_iwriteback;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic        CondExM, RegWriteM, MemtoRegM, PCSrcM, BaseWriteM;
    logic [3:0]  RdM, RnM, byteEnableM;
    logic [31:0] ALUResultM, BaseResultM, ReadDataM;
    logic        RegWriteW, PCSrcW, WbBusyW;
    logic [3:0]  RdW;
    logic [31:0] ResultW, RetiredW;

    int n_cmp = 0;
    int n_err = 0;

    iwriteback #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .CondExM(CondExM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .PCSrcM(PCSrcM), .BaseWriteM(BaseWriteM), .RdM(RdM), .RnM(RnM),
        .ALUResultM(ALUResultM), .BaseResultM(BaseResultM),
        .ReadDataM(ReadDataM), .byteEnableM(byteEnableM),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .PCSrcW(PCSrcW), .WbBusyW(WbBusyW), .RetiredW(RetiredW)
    );

    always #5 clk = ~clk;

    // One write-port cycle as seen from the register file.
    typedef struct packed {
        logic        rw;
        logic [3:0]  rd;
        logic [31:0] res;
        logic        pc;
        logic        busy;
        logic        retire;
    } beat_t;

    beat_t       q[$];
    logic [31:0] m_cnt;

    function automatic logic [31:0] ref_align(logic [31:0] d, logic [3:0] be);
        for (int k = 0; k < 4; k++)
            if (be == (4'd1 << k)) return (d >> (8 * k)) & 32'hFF;
        if (be == 4'b0011) return d & 32'hFFFF;
        if (be == 4'b1100) return d >> 16;
        return d;
    endfunction

    // Expand the instruction on the M inputs into its write-port beats.
    task automatic push_instr();
        beat_t b0, b1;
        logic  v;
        v       = CondExM;
        b0.rw   = v & RegWriteM;
        b0.rd   = RdM;
        b0.res  = MemtoRegM ? ref_align(ReadDataM, byteEnableM) : ALUResultM;
        b0.pc   = v & PCSrcM;
        b0.busy = v & BaseWriteM & (RdM != RnM);
        b0.retire = v & ~b0.busy;
        q.push_back(b0);
        if (b0.busy) begin
            b1.rw = 1'b1; b1.rd = RnM; b1.res = BaseResultM;
            b1.pc = (RnM == 4'd15); b1.busy = 1'b0; b1.retire = 1'b1;
            q.push_back(b1);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            q.delete();
            q.push_back('0);
            m_cnt = '0;
        end else if (!stall) begin
            if (q[0].retire) m_cnt = m_cnt + 1;
            void'(q.pop_front());
            if (q.size() == 0) push_instr();
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        beat_t e;
        e = q[0];
        check("RegWriteW", {31'b0, RegWriteW}, {31'b0, e.rw});
        check("RdW",       {28'b0, RdW},       {28'b0, e.rd});
        check("ResultW",   ResultW,            e.res);
        check("PCSrcW",    {31'b0, PCSrcW},    {31'b0, e.pc});
        check("WbBusyW",   {31'b0, WbBusyW},   {31'b0, e.busy});
        check("RetiredW",  RetiredW,           m_cnt);
    endtask

    task automatic cycle();
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_instr(input logic c, rw, m2r, pcs, bw,
                             input logic [3:0] rd, rn,
                             input logic [31:0] alu, base, rdata,
                             input logic [3:0] be);
        CondExM = c; RegWriteM = rw; MemtoRegM = m2r; PCSrcM = pcs;
        BaseWriteM = bw; RdM = rd; RnM = rn; ALUResultM = alu;
        BaseResultM = base; ReadDataM = rdata; byteEnableM = be;
    endtask

    initial begin
        bit saw_busy;
        reset = 1'b1; stall = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        @(posedge clk); model_edge(); #1;
        cycle();
        reset = 1'b0;
        check("reset_result", ResultW, 32'h0);

        // ADD r3 <- 0x10
        set_instr(1, 1, 0, 0, 0, 4'd3, 4'd0, 32'h10, 0, 0, 4'hF);
        cycle();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        check("add_rd", {28'b0, RdW}, 32'd3);
        check("add_res", ResultW, 32'h10);
        cycle();
        check("add_retired", RetiredW, 32'd1);

        // LDRB lane 2
        set_instr(1, 1, 1, 0, 0, 4'd5, 4'd0, 0, 0, 32'hAABBCCDD, 4'b0100);
        cycle();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        check("ldrb_res", ResultW, 32'h000000BB);

        // LDR with base writeback: two beats
        set_instr(1, 1, 1, 0, 1, 4'd1, 4'd2, 0, 32'h100, 32'h12345678, 4'hF);
        cycle();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        check("ldrwb_busy1", {31'b0, WbBusyW}, 32'd1);
        check("ldrwb_res1", ResultW, 32'h12345678);
        cycle();
        check("ldrwb_rd2", {28'b0, RdW}, 32'd2);
        check("ldrwb_res2", ResultW, 32'h100);
        cycle();

        // Rd == Rn: single beat, never busy
        set_instr(1, 1, 1, 0, 1, 4'd4, 4'd4, 0, 32'h200, 32'hCAFEF00D, 4'hF);
        cycle();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        check("rdrn_busy", {31'b0, WbBusyW}, 32'd0);
        check("rdrn_res", ResultW, 32'hCAFEF00D);
        cycle();

        // Condition failed
        set_instr(0, 1, 0, 1, 0, 4'd7, 4'd0, 32'h55, 0, 0, 4'hF);
        cycle();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        check("cfail_rw", {31'b0, RegWriteW}, 32'd0);
        cycle();

        // Stall in BASE, then reset mid-BASE
        set_instr(1, 1, 1, 0, 1, 4'd6, 4'd15, 0, 32'h300, 32'h77, 4'hF);
        cycle();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        cycle();
        stall = 1'b1;
        cycle();
        cycle();
        check("base_pc", {31'b0, PCSrcW}, 32'd1);
        stall = 1'b0; reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_retired", RetiredW, 32'd0);
        check("rst_rw", {31'b0, RegWriteW}, 32'd0);

        // Random traffic
        saw_busy = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 20);
            RdM = 4'($urandom);
            set_instr(1'($urandom_range(0, 99) < 80), 1'($urandom), 1'($urandom),
                      1'($urandom_range(0, 9) == 0), 1'($urandom),
                      RdM, ($urandom_range(0, 3) == 0) ? RdM : 4'($urandom),
                      $urandom, $urandom, $urandom, 4'($urandom));
            if (WbBusyW) saw_busy = 1'b1;
            cycle();
        end
        check("rand_saw_busy", {31'b0, saw_busy}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iwriteback.md
Name: iwriteback

Overview:
- Writeback stage of the pipelined ARM core, the write-side counterpart of the decode stage.
- Registers memory-stage results into a M/W pipeline register and aligns load data per byte-enable.
- Drives the register-file write port (RegWriteW, RdW, ResultW) and the PC redirect (PCSrcW).
- Sequences a second write-port cycle for loads with base writeback (pre/post-indexed LDR), requesting an upstream hold while it does so. Also keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; freezes M/W register, FSM and counter
- CondExM  in  1  instruction in M passed its condition check (valid)
- RegWriteM  in  1  primary register write requested
- MemtoRegM  in  1  result comes from load data
- PCSrcM  in  1  instruction writes PC (R15)
- BaseWriteM  in  1  load also updates base register Rn
- RdM  in  4  primary destination register
- RnM  in  4  base register
- ALUResultM  in  32  ALU result / effective address
- BaseResultM  in  32  updated base value
- ReadDataM  in  32  raw data-memory word
- byteEnableM  in  4  load lane select
- RegWriteW  out  1  register-file write enable
- RdW  out  4  register-file write address
- ResultW  out  32  register-file write data
- PCSrcW  out  1  PC redirect using ResultW
- WbBusyW  out  1  upstream must hold M stage this cycle
- RetiredW  out  CNT_W  count of retired valid instructions

Behaviour:
- Reset: M/W register cleared (valid=0); FSM=IDLE; RegWriteW=0, RdW=0, ResultW=0, PCSrcW=0, WbBusyW=0, RetiredW=0. Reset overrides stall.
- M/W register captures all M inputs on the rising edge when stall=0 and WbBusyW=0. Valid bit validW=CondExM. Latency M→W is one cycle.
- Load alignment, used when MemtoRegW=1:
  - byteEnable 1111: word.
  - 0001/0010/0100/1000: selected byte, zero-extended.
  - 0011/1100: selected halfword, zero-extended.
  - Any other code: word.
- FSM state IDLE:
  - RdW=RdW_reg; ResultW=aligned load if MemtoRegW else ALUResultW.
  - RegWriteW=validW&RegWriteW_reg; PCSrcW=validW&PCSrcW_reg.
  - If validW&BaseWriteW_reg&(RdW_reg≠RnW_reg): WbBusyW=1, and next state is BASE unless stall=1.
- FSM state BASE:
  - RdW=RnW_reg, ResultW=BaseResultW, RegWriteW=1, PCSrcW=(RnW_reg==15), WbBusyW=0.
  - Next state is IDLE unless stall=1.
- If Rd==Rn with base writeback: the base write is dropped, the load result wins, and the instruction completes in a single cycle (no BASE).
- If validW=0: all write strobes are 0 and BaseWrite is ignored.
- Stall:
  - During stall, outputs are held stable; re-asserting RegWriteW rewrites the same value (idempotent).
  - The FSM does not advance and the counter does not increment.
- RetiredW increments by 1 (wrapping at 2^CNT_W) on the final writeback cycle of a valid instruction with stall=0: IDLE without base write, or BASE.
- Reset asserted in BASE: return to IDLE; the pending base write is lost.

Test Plan:
- ADD result: CondExM=1, RegWriteM=1, RdM=3, ALUResultM=0x0000_0010 → next cycle RegWriteW=1, RdW=3, ResultW=0x10, RetiredW=1.
- LDRB lane 2: MemtoRegM=1, byteEnableM=0100, ReadDataM=0xAABBCCDD, RdM=5 → ResultW=0x0000_00BB, RdW=5.
- LDR with writeback: RdM=1, RnM=2, ReadDataM=0x1234_5678, BaseResultM=0x100 → cycle1: RdW=1, ResultW=0x12345678, WbBusyW=1; cycle2: RdW=2, ResultW=0x100, WbBusyW=0; M register held across cycle1; RetiredW +1 only after cycle2.
- Rd==Rn=4 with BaseWriteM → single cycle, RdW=4, ResultW=load data, WbBusyW never 1.
- Condition fail: CondExM=0, RegWriteM=1, PCSrcM=1 → RegWriteW=0, PCSrcW=0, RetiredW unchanged.
- Stall in BASE for 2 cycles, then reset mid-BASE → outputs held during stall, counter frozen; after reset all outputs 0, FSM IDLE, RetiredW=0.
